// File: rtl/imm_decode_pipe_pkg.sv
// Shared opcode constants, immediate class encoding and XLEN check
// for the immediate decode pipe.
package imm_decode_pipe_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_ZIMM  = 3'd6,
    IMM_NONE  = 3'd7
  } imm_type_t;

  function automatic bit xlen_legal(int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode_pipe_if.sv
// Fetch-side and consumer-side handshake bundle of the decode pipe.
// slave = pipe view, master = driver/consumer view.
interface imm_decode_pipe_if
  import imm_decode_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [INST_WIDTH-1:0] in_inst;
  logic [ADDR_WIDTH-1:0] in_pc;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_imm;
  imm_type_t             out_type;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_imm, out_type,
    output out_pc, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_type,
    input  out_pc, out_illegal
  );

endinterface

// File: rtl/imm_decode_pipe_core.sv
// Combinational RISC-V immediate extractor (imm_decode_core).
// Ports: inst_i -> imm_o (XLEN), type_o, illegal_o.
module imm_decode_core
  import imm_decode_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic [INST_WIDTH-1:0] inst_i,
  output logic [XLEN-1:0]       imm_o,
  output imm_type_t             type_o,
  output logic                  illegal_o
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_decode_core: XLEN must be 32 or 64");
  end

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [11:0] i12;
  logic [11:0] s12;
  logic [12:0] b13;
  logic [20:0] j21;
  logic [31:0] u32;
  logic [5:0]  sh6;
  logic [4:0]  zi5;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign i12 = inst_i[31:20];
  assign s12 = {inst_i[31:25], inst_i[11:7]};
  assign b13 = {inst_i[31], inst_i[7],
                inst_i[30:25], inst_i[11:8], 1'b0};
  assign j21 = {inst_i[31], inst_i[19:12],
                inst_i[20], inst_i[30:21], 1'b0};
  assign u32 = {inst_i[31:12], 12'h000};
  assign zi5 = inst_i[19:15];

  // RV64 shift amounts carry a sixth bit
  assign sh6 = (XLEN == 64) ? inst_i[25:20]
                            : {1'b0, inst_i[24:20]};

  logic is_opi, is_sh, is_i, is_s, is_b;
  logic is_j, is_u, is_sys, is_zi, is_none;

  assign is_opi  = (opc == OPC_OP_IMM);
  assign is_sh   = is_opi & ((f3 == 3'b001) | (f3 == 3'b101));
  assign is_i    = (is_opi & ~is_sh) | (opc == OPC_LOAD)
                 | (opc == OPC_JALR);
  assign is_s    = (opc == OPC_STORE);
  assign is_b    = (opc == OPC_BRANCH);
  assign is_j    = (opc == OPC_JAL);
  assign is_u    = (opc == OPC_LUI) | (opc == OPC_AUIPC);
  assign is_sys  = (opc == OPC_SYSTEM);
  assign is_zi   = is_sys & f3[2];
  assign is_none = (is_sys & ~f3[2]) | (opc == OPC_MISC_MEM);

  always_comb begin
    imm_o     = '0;
    type_o    = IMM_NONE;
    illegal_o = 1'b0;
    unique case (1'b1)
      is_sh: begin
        imm_o  = XLEN'(sh6);
        type_o = IMM_SHAMT;
      end
      is_i: begin
        imm_o  = XLEN'($signed(i12));
        type_o = IMM_I;
      end
      is_s: begin
        imm_o  = XLEN'($signed(s12));
        type_o = IMM_S;
      end
      is_b: begin
        imm_o  = XLEN'($signed(b13));
        type_o = IMM_B;
      end
      is_j: begin
        imm_o  = XLEN'($signed(j21));
        type_o = IMM_J;
      end
      is_u: begin
        imm_o  = XLEN'($signed(u32));
        type_o = IMM_U;
      end
      is_zi: begin
        imm_o  = XLEN'(zi5);
        type_o = IMM_ZIMM;
      end
      is_none: begin
        imm_o  = XLEN'(i12);
        type_o = IMM_NONE;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_pipe.sv
// Immediate decode stage: decode at input, two-entry output/skid buffer.
// Ports: clk, rst (sync, active-high), bus (slave handshake bundle).
module imm_decode_pipe
  import imm_decode_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  imm_decode_pipe_if.slave bus
);

  logic [XLEN-1:0] dec_imm;
  imm_type_t       dec_type;
  logic            dec_ill;

  imm_decode_core #(
    .XLEN       (XLEN),
    .INST_WIDTH (INST_WIDTH)
  ) u_core (
    .inst_i    (bus.in_inst),
    .imm_o     (dec_imm),
    .type_o    (dec_type),
    .illegal_o (dec_ill)
  );

  logic                  out_v_q, out_v_d;
  logic [XLEN-1:0]       out_imm_q, out_imm_d;
  imm_type_t             out_type_q, out_type_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                  out_ill_q, out_ill_d;

  logic                  sk_v_q, sk_v_d;
  logic [XLEN-1:0]       sk_imm_q, sk_imm_d;
  imm_type_t             sk_type_q, sk_type_d;
  logic [ADDR_WIDTH-1:0] sk_pc_q, sk_pc_d;
  logic                  sk_ill_q, sk_ill_d;

  logic in_fire;
  logic out_free;

  assign in_fire  = bus.in_valid & ~sk_v_q;
  assign out_free = ~out_v_q | bus.out_ready;

  always_comb begin
    out_v_d    = out_v_q;
    out_imm_d  = out_imm_q;
    out_type_d = out_type_q;
    out_pc_d   = out_pc_q;
    out_ill_d  = out_ill_q;
    sk_v_d     = sk_v_q;
    sk_imm_d   = sk_imm_q;
    sk_type_d  = sk_type_q;
    sk_pc_d    = sk_pc_q;
    sk_ill_d   = sk_ill_q;
    if (out_free) begin
      // skid is older than anything arriving, so it drains first
      if (sk_v_q) begin
        out_v_d    = 1'b1;
        out_imm_d  = sk_imm_q;
        out_type_d = sk_type_q;
        out_pc_d   = sk_pc_q;
        out_ill_d  = sk_ill_q;
        sk_v_d     = 1'b0;
      end else if (in_fire) begin
        out_v_d    = 1'b1;
        out_imm_d  = dec_imm;
        out_type_d = dec_type;
        out_pc_d   = bus.in_pc;
        out_ill_d  = dec_ill;
      end else begin
        out_v_d    = 1'b0;
      end
    end else if (in_fire) begin
      sk_v_d    = 1'b1;
      sk_imm_d  = dec_imm;
      sk_type_d = dec_type;
      sk_pc_d   = bus.in_pc;
      sk_ill_d  = dec_ill;
    end
    if (bus.flush) begin
      out_v_d = 1'b0;
      sk_v_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q    <= 1'b0;
      out_imm_q  <= '0;
      out_type_q <= IMM_NONE;
      out_pc_q   <= '0;
      out_ill_q  <= 1'b0;
      sk_v_q     <= 1'b0;
      sk_imm_q   <= '0;
      sk_type_q  <= IMM_NONE;
      sk_pc_q    <= '0;
      sk_ill_q   <= 1'b0;
    end else begin
      out_v_q    <= out_v_d;
      out_imm_q  <= out_imm_d;
      out_type_q <= out_type_d;
      out_pc_q   <= out_pc_d;
      out_ill_q  <= out_ill_d;
      sk_v_q     <= sk_v_d;
      sk_imm_q   <= sk_imm_d;
      sk_type_q  <= sk_type_d;
      sk_pc_q    <= sk_pc_d;
      sk_ill_q   <= sk_ill_d;
    end
  end

  assign bus.in_ready    = ~sk_v_q;
  assign bus.out_valid   = out_v_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_type    = out_type_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_illegal = out_ill_q;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: XLEN=32 and XLEN=64 instances driven
// in lockstep, directed scenarios plus queue-model random traffic.
module tb_imm_decode_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  imm_decode_pipe_if #(.XLEN(32)) b32 ();
  imm_decode_pipe_if #(.XLEN(64)) b64 ();

  imm_decode_pipe #(.XLEN(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32.slave)
  );

  imm_decode_pipe #(.XLEN(64)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];

  task automatic drv(input logic v, input logic [31:0] inst,
                     input logic [31:0] pc, input logic ordy,
                     input logic fl);
    b32.in_valid  = v;
    b32.in_inst   = inst;
    b32.in_pc     = pc;
    b32.out_ready = ordy;
    b32.flush     = fl;
    b64.in_valid  = v;
    b64.in_inst   = inst;
    b64.in_pc     = pc;
    b64.out_ready = ordy;
    b64.flush     = fl;
  endtask

  function automatic logic [63:0] sx(input logic [63:0] v,
                                     input int bits);
    longint t;
    t = longint'(v << (64 - bits));
    return 64'(t >>> (64 - bits));
  endfunction

  // reference decode, built from field arithmetic
  function automatic void ref_dec(input logic [31:0] in,
                                  input int xl,
                                  output logic [63:0] imm,
                                  output logic [2:0] ty,
                                  output logic il);
    logic [6:0] op;
    logic [2:0] f3;
    logic [63:0] v;
    op = in[6:0];
    f3 = in[14:12];
    imm = 64'd0;
    ty = 3'd7;
    il = 1'b0;
    if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
      ty = 3'd5;
      imm = (xl == 64) ? 64'(in[25:20]) : 64'(in[24:20]);
    end else if (op == 7'h13 || op == 7'h03 || op == 7'h67) begin
      ty = 3'd0;
      imm = sx(64'(in[31:20]), 12);
    end else if (op == 7'h23) begin
      ty = 3'd1;
      v = 64'(in[31:25]) * 32 + 64'(in[11:7]);
      imm = sx(v, 12);
    end else if (op == 7'h63) begin
      ty = 3'd2;
      v = 64'(in[31]) * 4096 + 64'(in[7]) * 2048
        + 64'(in[30:25]) * 32 + 64'(in[11:8]) * 2;
      imm = sx(v, 13);
    end else if (op == 7'h6F) begin
      ty = 3'd4;
      v = 64'(in[31]) * (1 << 20) + 64'(in[19:12]) * 4096
        + 64'(in[20]) * 2048 + 64'(in[30:21]) * 2;
      imm = sx(v, 21);
    end else if (op == 7'h37 || op == 7'h17) begin
      ty = 3'd3;
      imm = sx(64'(in[31:12]) * 4096, 32);
    end else if (op == 7'h73 && in[14]) begin
      ty = 3'd6;
      imm = 64'(in[19:15]);
    end else if (op == 7'h73 || op == 7'h0F) begin
      ty = 3'd7;
      imm = 64'(in[31:20]);
    end else begin
      il = 1'b1;
    end
    if (xl == 32) imm = imm & 64'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11];
    logic [31:0] r;
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h37,
            7'h63, 7'h67, 7'h6F, 7'h73, 7'h13};
    r = $urandom();
    if ($urandom_range(0, 7) != 0)
      r[6:0] = ops[$urandom_range(0, 10)];
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b/%b want 0",
               b32.out_valid, b64.out_valid);
    end
    checks++;
    if (b32.out_imm !== 32'd0 || b64.out_imm !== 64'd0) begin
      errors++;
      $display("FAIL reset_imm got %h/%h want 0",
               b32.out_imm, b64.out_imm);
    end
    checks++;
    if (b32.out_type !== 3'd7 || b64.out_type !== 3'd7) begin
      errors++;
      $display("FAIL reset_type got %0d/%0d want 7",
               b32.out_type, b64.out_type);
    end
    checks++;
    if (b32.out_pc !== 32'd0 || b32.out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_pc_ill got %h/%b want 0/0",
               b32.out_pc, b32.out_illegal);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b32.in_ready !== 1'b1 || b64.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b/%b want 1",
               b32.in_ready, b64.in_ready);
    end
  endtask

  task automatic test_addi();
    drv(1'b1, 32'hFFF00093, 32'h1000, 1'b1, 1'b0);
    @(negedge clk);
    drv(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL addi32 got v=%b imm=%h want 1/ffffffff",
               b32.out_valid, b32.out_imm);
    end
    checks++;
    if (b32.out_type !== 3'd0 || b32.out_pc !== 32'h1000) begin
      errors++;
      $display("FAIL addi_type_pc got %0d/%h want 0/1000",
               b32.out_type, b32.out_pc);
    end
    checks++;
    if (b64.out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL addi64 got %h want ffffffffffffffff",
               b64.out_imm);
    end
    @(negedge clk);
  endtask

  task automatic test_srai();
    drv(1'b1, 32'h40315093, 32'h1004, 1'b1, 1'b0);
    @(negedge clk);
    drv(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (b32.out_imm !== 32'h3 || b32.out_type !== 3'd5) begin
      errors++;
      $display("FAIL srai got imm=%h type=%0d want 3/5",
               b32.out_imm, b32.out_type);
    end
    checks++;
    if (b32.out_imm === 32'h403) begin
      errors++;
      $display("FAIL srai_not403 got %h want 3", b32.out_imm);
    end
    checks++;
    if (b64.out_imm !== 64'h3 || b64.out_type !== 3'd5) begin
      errors++;
      $display("FAIL srai64 got imm=%h type=%0d want 3/5",
               b64.out_imm, b64.out_type);
    end
    @(negedge clk);
  endtask

  task automatic fill_two();
    drv(1'b1, 32'hFE000EE3, 32'h200, 1'b0, 1'b0);
    @(negedge clk);
    drv(1'b1, 32'h3002D0F3, 32'h204, 1'b0, 1'b0);
    @(negedge clk);
    drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_skid();
    fill_two();
    checks++;
    if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL skid_full got rdy=%b v=%b want 0/1",
               b32.in_ready, b32.out_valid);
    end
    @(negedge clk);
    checks++;
    if (b32.out_imm !== 32'hFFFFFFFC || b32.out_type !== 3'd2
        || b32.out_pc !== 32'h200) begin
      errors++;
      $display("FAIL skid_hold got %h/%0d/%h want fffffffc/2/200",
               b32.out_imm, b32.out_type, b32.out_pc);
    end
    drv(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'h5
        || b32.out_type !== 3'd6 || b32.out_pc !== 32'h204) begin
      errors++;
      $display("FAIL skid_second got %b/%h/%0d/%h want 1/5/6/204",
               b32.out_valid, b32.out_imm, b32.out_type, b32.out_pc);
    end
    checks++;
    if (b64.out_imm !== 64'h5 || b32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_drain got %h/%b want 5/1",
               b64.out_imm, b32.in_ready);
    end
    @(negedge clk);
    checks++;
    if (b32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL skid_empty got %b want 0", b32.out_valid);
    end
  endtask

  task automatic test_flush(input bit use_rst);
    fill_two();
    drv(1'b1, 32'h00000013, 32'h300, 1'b1, !use_rst);
    rst = use_rst;
    @(negedge clk);
    rst = 1'b0;
    drv(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1
        || b64.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush%0d got v=%b rdy=%b want 0/1",
               use_rst, b32.out_valid, b32.in_ready);
    end
    if (use_rst) begin
      checks++;
      if (b32.out_imm !== 32'd0 || b32.out_type !== 3'd7
          || b32.out_pc !== 32'd0 || b64.out_imm !== 64'd0) begin
        errors++;
        $display("FAIL midrst_vals got %h/%0d/%h want 0/7/0",
                 b32.out_imm, b32.out_type, b32.out_pc);
      end
    end
    @(negedge clk);
    checks++;
    if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush%0d_nodeliver got %b want 0",
               use_rst, b32.out_valid);
    end
  endtask

  task automatic test_lui();
    drv(1'b1, 32'h80000537, 32'h400, 1'b1, 1'b0);
    @(negedge clk);
    drv(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (b64.out_imm !== 64'hFFFF_FFFF_8000_0000
        || b64.out_type !== 3'd3) begin
      errors++;
      $display("FAIL lui64 got %h/%0d want ffffffff80000000/3",
               b64.out_imm, b64.out_type);
    end
    checks++;
    if (b32.out_imm !== 32'h8000_0000 || b32.out_type !== 3'd3) begin
      errors++;
      $display("FAIL lui32 got %h/%0d want 80000000/3",
               b32.out_imm, b32.out_type);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    drv(1'b1, 32'h0000007F, 32'h500, 1'b1, 1'b0);
    @(negedge clk);
    drv(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (b32.out_valid !== 1'b1 || b32.out_illegal !== 1'b1
        || b32.out_imm !== 32'd0 || b32.out_type !== 3'd7) begin
      errors++;
      $display("FAIL illegal32 got %b/%b/%h/%0d want 1/1/0/7",
               b32.out_valid, b32.out_illegal,
               b32.out_imm, b32.out_type);
    end
    checks++;
    if (b64.out_illegal !== 1'b1 || b64.out_imm !== 64'd0) begin
      errors++;
      $display("FAIL illegal64 got %b/%h want 1/0",
               b64.out_illegal, b64.out_imm);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [63:0] ei;
    logic [2:0]  et;
    logic        el;
    logic        v, ordy, fl, eov, eir;
    logic [31:0] inst, pc;
    drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      eov = (q.size() > 0);
      eir = (q.size() < 2);
      checks++;
      if (b32.out_valid !== eov || b32.in_ready !== eir
          || b64.out_valid !== eov || b64.in_ready !== eir) begin
        errors++;
        $display("FAIL rnd_hs cyc %0d got v=%b rdy=%b want %b/%b",
                 n, b32.out_valid, b32.in_ready, eov, eir);
      end
      if (eov) begin
        ref_dec(q[0].inst, 32, ei, et, el);
        checks++;
        if (b32.out_imm !== ei[31:0] || b32.out_type !== et
            || b32.out_illegal !== el || b32.out_pc !== q[0].pc) begin
          errors++;
          $display("FAIL rnd32 inst %h got %h/%0d/%b/%h want %h/%0d/%b/%h",
                   q[0].inst, b32.out_imm, b32.out_type,
                   b32.out_illegal, b32.out_pc,
                   ei[31:0], et, el, q[0].pc);
        end
        ref_dec(q[0].inst, 64, ei, et, el);
        checks++;
        if (b64.out_imm !== ei || b64.out_type !== et
            || b64.out_illegal !== el || b64.out_pc !== q[0].pc) begin
          errors++;
          $display("FAIL rnd64 inst %h got %h/%0d want %h/%0d",
                   q[0].inst, b64.out_imm, b64.out_type, ei, et);
        end
      end
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      inst = rand_inst();
      pc   = $urandom();
      drv(v, inst, pc, ordy, fl);
      if (fl) begin
        q.delete();
      end else begin
        if (eov && ordy) void'(q.pop_front());
        if (v && eir) q.push_back('{inst: inst, pc: pc});
      end
      @(negedge clk);
    end
    drv(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_addi();
    test_srai();
    test_skid();
    test_flush(1'b0);
    test_flush(1'b1);
    test_lui();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
